// File: rtl/quad_decoder.sv
// Quadrature decoder with input synchronizers, per-channel glitch filters,
// a saturating position register, a step/direction pulse and a sticky error
// flag for illegal (double-bit) transitions.
// A short INIT phase after reset lets the filters settle on the power-up
// input level before any transition is decoded.
module quad_decoder #(
    parameter int N    = 8,
    parameter int FILT = 3
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         QA,
    input  logic         QB,
    input  logic         LOAD,
    input  logic [N-1:0] LOAD_VAL,
    input  logic         CLR_ERR,
    output logic [N-1:0] Y,
    output logic         STEP,
    output logic         DIR,
    output logic         ERR
);

    // Run counter width covers FILT up to 15.
    localparam int CW = 4;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT - 1);

    // INIT phase length; leaving INIT on the edge where the counter equals
    // this value means PREV still tracks on that edge, so the first RUN
    // comparison already sees the settled power-up level.
    localparam logic [4:0] INIT_LEN = 5'(FILT + 2);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [N-1:0] Y_MAX = '1;
    localparam logic [N-1:0] Y_MIN = '0;

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0] raw;
    logic [1:0] filt;

    assign raw = {QA, QB};

    // ------------------------------------------------------------------
    // Per-channel synchronizer and glitch filter
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          filt_reg;
            logic          filt_next;
            logic [CW-1:0] run_cnt_reg;
            logic [CW-1:0] run_cnt_next;

            // Filtered bit flips only after FILT consecutive differing edges;
            // any agreeing edge restarts the run.
            always_comb begin
                filt_next    = filt_reg;
                run_cnt_next = '0;
                if (sync2_reg != filt_reg) begin
                    if (run_cnt_reg == FILT_LAST) begin
                        filt_next = sync2_reg;
                    end else begin
                        run_cnt_next = run_cnt_reg + 1'b1;
                    end
                end
            end

            // Two-flop synchronizer followed by the filter state.
            always_ff @(posedge CLK) begin
                if (!N_RESET) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    filt_reg    <= 1'b0;
                    run_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= raw[gi];
                    sync2_reg   <= sync1_reg;
                    filt_reg    <= filt_next;
                    run_cnt_reg <= run_cnt_next;
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transition classification
    // ------------------------------------------------------------------
    logic [1:0] prev_reg;
    logic       is_up;
    logic       is_down;
    logic       is_illegal;

    // Compare the previous filtered pair with the current one.
    always_comb begin
        is_up      = 1'b0;
        is_down    = 1'b0;
        is_illegal = 1'b0;
        case ({prev_reg, filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up      = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_down    = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_illegal = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: INIT settles the filters, RUN decodes
    // ------------------------------------------------------------------
    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic [4:0] init_cnt_reg;
    logic [4:0] init_cnt_next;
    logic       in_run;

    // INIT counts its cycles, then hands over to RUN for good.
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == INIT_LEN) begin
                    state_next    = ST_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                state_next    = ST_RUN;
                init_cnt_next = '0;
            end
            default: begin
                state_next    = ST_INIT;
                init_cnt_next = '0;
            end
        endcase
    end

    assign in_run = (state_reg == ST_RUN);

    // ------------------------------------------------------------------
    // Position, step, direction and error
    // ------------------------------------------------------------------
    logic [N-1:0] y_reg;
    logic [N-1:0] y_next;
    logic         step_reg;
    logic         step_next;
    logic         dir_reg;
    logic         dir_next;
    logic         err_reg;
    logic         err_next;
    logic         step_valid;

    assign step_valid = in_run && (is_up || is_down);

    // LOAD overrides a concurrent step (no pulse, DIR kept); Y saturates at
    // both ends while STEP/DIR still report the step; error set beats clear.
    always_comb begin
        y_next    = y_reg;
        step_next = 1'b0;
        dir_next  = dir_reg;
        err_next  = err_reg;

        if (LOAD) begin
            y_next = LOAD_VAL;
        end else if (step_valid) begin
            step_next = 1'b1;
            dir_next  = is_up;
            if (is_up && (y_reg != Y_MAX)) begin
                y_next = y_reg + 1'b1;
            end else if (is_down && (y_reg != Y_MIN)) begin
                y_next = y_reg - 1'b1;
            end
        end

        if (in_run && is_illegal) begin
            err_next = 1'b1;
        end else if (CLR_ERR) begin
            err_next = 1'b0;
        end
    end

    // Register FSM, PREV and all outputs; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            prev_reg     <= 2'b00;
            y_reg        <= '0;
            step_reg     <= 1'b0;
            dir_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            prev_reg     <= filt;
            y_reg        <= y_next;
            step_reg     <= step_next;
            dir_reg      <= dir_next;
            err_reg      <= err_next;
        end
    end

    assign Y    = y_reg;
    assign STEP = step_reg;
    assign DIR  = dir_reg;
    assign ERR  = err_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder (N=8, FILT=3).
module tb_quad_decoder;

    localparam int N    = 8;
    localparam int FILT = 3;

    logic         CLK;
    logic         N_RESET;
    logic         QA;
    logic         QB;
    logic         LOAD;
    logic [N-1:0] LOAD_VAL;
    logic         CLR_ERR;
    logic [N-1:0] Y;
    logic         STEP;
    logic         DIR;
    logic         ERR;

    int total;
    int bad;
    int step_cnt;
    int base;

    quad_decoder #(.N(N), .FILT(FILT)) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .QA       (QA),
        .QB       (QB),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .CLR_ERR  (CLR_ERR),
        .Y        (Y),
        .STEP     (STEP),
        .DIR      (DIR),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count STEP pulses away from the active edge.
    always @(negedge CLK) begin
        if (STEP === 1'b1) step_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic a, input logic b);
        QA = a;
        QB = b;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("chk %s obs=%0h exp=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        step_cnt = 0;
        N_RESET  = 1'b0;
        QA       = 1'b1;
        QB       = 1'b1;
        LOAD     = 1'b0;
        LOAD_VAL = '0;
        CLR_ERR  = 1'b0;

        // Reset with both channels high.
        tick(3);
        check("rst_y",    32'(Y),    32'h0);
        check("rst_step", 32'(STEP), 32'h0);
        check("rst_dir",  32'(DIR),  32'h0);
        check("rst_err",  32'(ERR),  32'h0);
        N_RESET = 1'b1;
        base = step_cnt;
        tick(10);
        check("pwr_err",   32'(ERR),             32'h0);
        check("pwr_y",     32'(Y),               32'h0);
        check("pwr_steps", 32'(step_cnt - base), 32'h0);

        // Up sequence 11->10->00->01 with latency check on the first step.
        base = step_cnt;
        drive(1'b1, 1'b0);
        tick(5);
        check("lat_y_t4",    32'(Y),    32'h0);
        check("lat_step_t4", 32'(STEP), 32'h0);
        tick(1);
        check("lat_y_t5",    32'(Y),    32'h1);
        check("lat_step_t5", 32'(STEP), 32'h1);
        tick(2);
        drive(1'b0, 1'b0); tick(8);
        drive(1'b0, 1'b1); tick(8);
        check("up_y",     32'(Y),               32'h3);
        check("up_dir",   32'(DIR),             32'h1);
        check("up_err",   32'(ERR),             32'h0);
        check("up_steps", 32'(step_cnt - base), 32'h3);

        // Load 254, then saturate at the top, then one down step.
        LOAD = 1'b1; LOAD_VAL = 8'd254; tick(1); LOAD = 1'b0;
        check("ld254_y", 32'(Y), 32'd254);
        base = step_cnt;
        drive(1'b1, 1'b1); tick(8);
        check("sat_hi_y1", 32'(Y), 32'd255);
        drive(1'b1, 1'b0); tick(8);
        check("sat_hi_y2", 32'(Y), 32'd255);
        drive(1'b0, 1'b0); tick(8);
        check("sat_hi_y3",    32'(Y),               32'd255);
        check("sat_hi_steps", 32'(step_cnt - base), 32'h3);
        drive(1'b1, 1'b0); tick(8);
        check("dn_y",   32'(Y),   32'd254);
        check("dn_dir", 32'(DIR), 32'h0);

        // Load 0, two down steps saturate at the bottom.
        LOAD = 1'b1; LOAD_VAL = 8'd0; tick(1); LOAD = 1'b0;
        base = step_cnt;
        drive(1'b1, 1'b1); tick(8);
        drive(1'b0, 1'b1); tick(8);
        check("sat_lo_y",     32'(Y),               32'h0);
        check("sat_lo_steps", 32'(step_cnt - base), 32'h2);
        check("sat_lo_dir",   32'(DIR),             32'h0);

        // Two-cycle glitch on QA must be filtered out.
        base = step_cnt;
        drive(1'b1, 1'b1); tick(2);
        drive(1'b0, 1'b1); tick(10);
        check("glitch_steps", 32'(step_cnt - base), 32'h0);
        check("glitch_y",     32'(Y),               32'h0);
        check("glitch_err",   32'(ERR),             32'h0);

        // Both channels toggle together: illegal.
        drive(1'b1, 1'b0); tick(8);
        check("ill_err",   32'(ERR),             32'h1);
        check("ill_y",     32'(Y),               32'h0);
        check("ill_steps", 32'(step_cnt - base), 32'h0);
        CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0;
        check("clr_err", 32'(ERR), 32'h0);

        // LOAD on the same edge as a valid up step (10->00).
        base = step_cnt;
        drive(1'b0, 1'b0);
        tick(5);
        LOAD = 1'b1; LOAD_VAL = 8'h40; tick(1); LOAD = 1'b0; LOAD_VAL = '0;
        check("ldstep_y",    32'(Y),    32'h40);
        check("ldstep_step", 32'(STEP), 32'h0);
        check("ldstep_dir",  32'(DIR),  32'h0);
        tick(2);
        check("ldstep_steps", 32'(step_cnt - base), 32'h0);

        // Illegal 00->11 on the same edge as CLR_ERR: set wins.
        drive(1'b1, 1'b1);
        tick(5);
        CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0;
        check("setwins_err", 32'(ERR), 32'h1);
        tick(2);
        check("setwins_err2", 32'(ERR), 32'h1);
        check("setwins_y",    32'(Y),   32'h40);

        // One-cycle reset mid-operation, inputs held at 11.
        N_RESET = 1'b0; tick(1);
        check("mrst_y",   32'(Y),   32'h0);
        check("mrst_err", 32'(ERR), 32'h0);
        check("mrst_dir", 32'(DIR), 32'h0);
        N_RESET = 1'b1;
        base = step_cnt;
        tick(12);
        check("mrst_steps", 32'(step_cnt - base), 32'h0);
        check("mrst_err2",  32'(ERR),             32'h0);

        // Decoding resumes: down step 11->01 at Y=0.
        drive(1'b0, 1'b1); tick(8);
        check("resume_steps", 32'(step_cnt - base), 32'h1);
        check("resume_y",     32'(Y),               32'h0);
        check("resume_err",   32'(ERR),             32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
